// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - word handshake between the byte producer and uart_tx_frame
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serialiser: start, LSB-first data, optional parity, stop bits
// Optional parity bit compiled in with macro UART_TX_PARITY_EN.
module uart_tx_frame #(
   parameter int BAUD_DIV   = 501,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_frame_if.slave tx_if,
   output logic           txd,
   output logic           tx_busy,
   output logic           tx_done
);
   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

   generate
      if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
          PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
         $error("uart_tx_frame: illegal parameter value");
      end
   endgenerate

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   logic r_par;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t               r_state;
   logic [CNT_W-1:0]     r_baud;
   logic [IDX_W-1:0]     r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [1:0]           r_stop;
   logic                 r_txd;
   logic                 r_done;
   logic                 w_bit_end;
   logic                 w_accept;

   assign w_bit_end      = (r_baud == BAUD_LAST);
   assign w_accept       = tx_if.tx_valid && (r_state == S_IDLE);
   assign tx_if.tx_ready = (r_state == S_IDLE);
   assign tx_busy        = (r_state != S_IDLE);
   assign txd            = r_txd;
   assign tx_done        = r_done;

   // r_txd is loaded with the value of the bit that starts on the same edge,
   // so the line changes exactly when the state does.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_stop  <= '0;
         r_txd   <= 1'b1;
         r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_accept || w_bit_end) begin
            r_baud <= '0;
         end else if (r_state != S_IDLE) begin
            r_baud <= r_baud + 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (w_accept) begin
                  r_shift <= tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
                  r_par   <= (^tx_if.tx_data) ^ 1'(PARITY_ODD);
`endif
                  r_txd   <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_idx   <= '0;
                  r_txd   <= r_shift[0];
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_shift <= r_shift >> 1;
                  if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                     r_txd   <= r_par;
                     r_state <= S_PARITY;
`else
                     r_txd   <= 1'b1;
                     r_stop  <= '0;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_idx <= r_idx + 1'b1;
                     r_txd <= r_shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_txd   <= 1'b1;
                  r_stop  <= '0;
                  r_state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  if (r_stop == STOP_LAST) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_stop <= r_stop + 1'b1;
                  end
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   sel      = 0;

   always #5 clk = ~clk;

   uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
   uart_tx_frame_if #(.DATA_BITS(5)) if_b ();
   uart_tx_frame_if #(.DATA_BITS(8)) if_c ();
   logic txd_a, busy_a, done_a;
   logic txd_b, busy_b, done_b;
   logic txd_c, busy_c, done_c;

   uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
      .clk(clk), .rst(rst), .tx_if(if_a), .txd(txd_a), .tx_busy(busy_a), .tx_done(done_a));
   uart_tx_frame #(.BAUD_DIV(3), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
      .clk(clk), .rst(rst), .tx_if(if_b), .txd(txd_b), .tx_busy(busy_b), .tx_done(done_b));
   uart_tx_frame #(.BAUD_DIV(2), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_c (
      .clk(clk), .rst(rst), .tx_if(if_c), .txd(txd_c), .tx_busy(busy_c), .tx_done(done_c));
`ifdef UART_TX_PARITY_EN
   uart_tx_frame_if #(.DATA_BITS(8)) if_d ();
   logic txd_d, busy_d, done_d;
   uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_d (
      .clk(clk), .rst(rst), .tx_if(if_d), .txd(txd_d), .tx_busy(busy_d), .tx_done(done_d));
`endif

   logic m_txd, m_busy, m_done, m_ready;
   always_comb begin
      m_txd = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ready = 1'b0;
      case (sel)
         0: begin m_txd = txd_a; m_busy = busy_a; m_done = done_a; m_ready = if_a.tx_ready; end
         1: begin m_txd = txd_b; m_busy = busy_b; m_done = done_b; m_ready = if_b.tx_ready; end
         2: begin m_txd = txd_c; m_busy = busy_c; m_done = done_c; m_ready = if_c.tx_ready; end
`ifdef UART_TX_PARITY_EN
         3: begin m_txd = txd_d; m_busy = busy_d; m_done = done_d; m_ready = if_d.tx_ready; end
`endif
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [8:0] d);
      case (sel)
         0: begin if_a.tx_valid = v; if_a.tx_data = d[7:0]; end
         1: begin if_b.tx_valid = v; if_b.tx_data = d[4:0]; end
         2: begin if_c.tx_valid = v; if_c.tx_data = d[7:0]; end
`ifdef UART_TX_PARITY_EN
         3: begin if_d.tx_valid = v; if_d.tx_data = d[7:0]; end
`endif
         default: ;
      endcase
   endtask

   // Called at a falling edge; returns at the falling edge of cycle F+1.
   // bits[i] is the i-th serial bit of the frame (bit 0 = start bit).
   task automatic send_frame(input string tag, input logic [8:0] data, input logic [11:0] bits,
                             input int nbits, input int baud, input bit pre, input bit hold,
                             input logic [8:0] nxt);
      int f;
      f = nbits * baud;
      if (!pre) drive(1'b1, data);
      @(posedge clk);
      @(negedge clk);
      drive(hold, nxt);
      for (int k = 1; k <= f; k++) begin
         check($sformatf("%s txd c%0d", tag, k), m_txd, bits[(k-1)/baud]);
         check($sformatf("%s busy c%0d", tag, k), m_busy, 1'b1);
         check($sformatf("%s done c%0d", tag, k), m_done, 1'b0);
         @(negedge clk);
      end
      check({tag, " done F+1"}, m_done, 1'b1);
      check({tag, " ready F+1"}, m_ready, 1'b1);
      check({tag, " txd F+1"}, m_txd, 1'b1);
   endtask

   task automatic after_frame(input string tag);
      @(negedge clk);
      check({tag, " done F+2"}, m_done, 1'b0);
      check({tag, " ready F+2"}, m_ready, 1'b1);
   endtask

   initial begin
      if_a.tx_valid = 1'b0; if_a.tx_data = '0;
      if_b.tx_valid = 1'b0; if_b.tx_data = '0;
      if_c.tx_valid = 1'b0; if_c.tx_data = '0;
`ifdef UART_TX_PARITY_EN
      if_d.tx_valid = 1'b0; if_d.tx_data = '0;
`endif
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("reset txd dut%0d", s), m_txd, 1'b1);
         check($sformatf("reset ready dut%0d", s), m_ready, 1'b1);
         check($sformatf("reset busy dut%0d", s), m_busy, 1'b0);
         check($sformatf("reset done dut%0d", s), m_done, 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);

`ifdef UART_TX_PARITY_EN
      sel = 0;
      send_frame("basic_a5_even", 9'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 1'b0, 1'b0, 9'h0);
      after_frame("basic_a5_even");
      sel = 3;
      send_frame("a5_odd", 9'hA5, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 4, 1'b0, 1'b0, 9'h0);
      after_frame("a5_odd");
      sel = 0;
      send_frame("01_even", 9'h01, {1'b1, 1'b1, 8'h01, 1'b0}, 11, 4, 1'b0, 1'b0, 9'h0);
      after_frame("01_even");
      sel = 1;
      send_frame("framing_1f", 9'h1F, {2'b11, 1'b1, 5'h1F, 1'b0}, 9, 3, 1'b0, 1'b0, 9'h0);
      after_frame("framing_1f");
      sel = 2;
      send_frame("min_div_ff", 9'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 11, 2, 1'b0, 1'b0, 9'h0);
      after_frame("min_div_ff");
      sel = 0;
      send_frame("b2b_55", 9'h55, {1'b1, 1'b0, 8'h55, 1'b0}, 11, 4, 1'b0, 1'b1, 9'hAA);
      send_frame("b2b_aa", 9'h0, {1'b1, 1'b0, 8'hAA, 1'b0}, 11, 4, 1'b1, 1'b0, 9'h0);
      after_frame("b2b_aa");
`else
      sel = 0;
      send_frame("basic_a5", 9'hA5, {1'b1, 8'hA5, 1'b0}, 10, 4, 1'b0, 1'b0, 9'h0);
      after_frame("basic_a5");
      sel = 1;
      send_frame("framing_1f", 9'h1F, {2'b11, 5'h1F, 1'b0}, 8, 3, 1'b0, 1'b0, 9'h0);
      after_frame("framing_1f");
      sel = 2;
      send_frame("min_div_ff", 9'hFF, {1'b1, 8'hFF, 1'b0}, 10, 2, 1'b0, 1'b0, 9'h0);
      after_frame("min_div_ff");
      sel = 0;
      send_frame("b2b_55", 9'h55, {1'b1, 8'h55, 1'b0}, 10, 4, 1'b0, 1'b1, 9'hAA);
      send_frame("b2b_aa", 9'h0, {1'b1, 8'hAA, 1'b0}, 10, 4, 1'b1, 1'b0, 9'h0);
      after_frame("b2b_aa");
`endif

      // Abort a frame of 0x00 during its third data bit (cycles 13..16).
      sel = 0;
      drive(1'b1, 9'h00);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 9'h00);
      repeat (13) @(negedge clk);
      check("abort pre txd", m_txd, 1'b0);
      check("abort pre busy", m_busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("abort async txd", m_txd, 1'b1);
      check("abort async ready", m_ready, 1'b1);
      check("abort async busy", m_busy, 1'b0);
      check("abort async done", m_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 48; k++) begin
         @(negedge clk);
         check($sformatf("abort no done c%0d", k), m_done, 1'b0);
      end
`ifdef UART_TX_PARITY_EN
      send_frame("post_rst_3c", 9'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 4, 1'b0, 1'b0, 9'h0);
`else
      send_frame("post_rst_3c", 9'h3C, {1'b1, 8'h3C, 1'b0}, 10, 4, 1'b0, 1'b0, 9'h0);
`endif
      after_frame("post_rst_3c");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
